// File: rtl/pad_spi_regs.sv
// Oversampled 3-wire serial register interface between the padframe inputs and the core.
// A 16-bit frame (RW, ADDR[6:0], DATA[7:0]) drives the OUT/DIR registers or reads back via MISO.
module pad_spi_regs #(
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in,
  output logic [7:0]  out,
  output logic [15:0] oeb,
  output logic        miso,
  output logic        miso_oeb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Synchronizer reset value: SCK low, CSB high, everything else low.
  localparam logic [7:0] IN_RST = 8'h04;

  logic [7:0] in_s1_q, in_s1_d;
  logic [7:0] in_s2_q, in_s2_d;
  logic [7:0] in_a_q, in_a_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic [1:0] vld_q, vld_d;
  logic       armed_q, armed_d;
  logic       miso_oeb_q, miso_oeb_d;
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] out_q, out_d;
  logic [7:0] dir_q, dir_d;
  logic       miso_q, miso_d;
  logic [7:0] byte_s;
  logic [7:0] rdata_s;

  always_comb begin
    in_s1_d    = in;
    in_s2_d    = in_s1_q;
    // in_a_q is the aligned copy seen by the FSM in the same cycle as the edge pulses
    in_a_d     = in_s2_q;
    rise_d     = in_s2_q[0] & ~in_a_q[0];
    fall_d     = ~in_s2_q[0] & in_a_q[0];
    vld_d      = {vld_q[0], 1'b1};
    // Only accept a frame after a genuine post-reset CSB high has been observed
    armed_d    = armed_q | (vld_q[1] & in_s2_q[2]);
    miso_oeb_d = in_s2_q[2];

    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    tx_d    = tx_q;
    out_d   = out_q;
    dir_d   = dir_q;
    miso_d  = miso_q;

    byte_s  = {shift_q[6:0], in_a_q[1]};
    rdata_s = 8'h00;
    if (byte_s[6:2] == 5'd0) begin
      case (byte_s[1:0])
        2'd0:    rdata_s = out_q;
        2'd1:    rdata_s = dir_q;
        2'd2:    rdata_s = in_a_q;
        2'd3:    rdata_s = ID_VALUE;
        default: rdata_s = 8'h00;
      endcase
    end

    if (in_a_q[2]) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          cnt_d  = 3'd0;
          if (armed_q) begin
            state_d = CMD;
          end
        end
        CMD: begin
          if (rise_q) begin
            shift_d = byte_s;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d    = byte_s[7];
              addr_d  = byte_s[6:0];
              tx_d    = rdata_s;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (rise_q) begin
            shift_d = byte_s;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (rw_q && (addr_q[6:2] == 5'd0)) begin
                case (addr_q[1:0])
                  2'd0:    out_d = byte_s;
                  2'd1:    dir_d = byte_s;
                  default: out_d = out_q;
                endcase
              end
              state_d = DONE;
              miso_d  = 1'b0;
            end
          end else if (fall_q && !rw_q) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        DONE:    miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_s1_q    <= IN_RST;
      in_s2_q    <= IN_RST;
      in_a_q     <= IN_RST;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
      miso_oeb_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      addr_q     <= 7'd0;
      tx_q       <= 8'h00;
      out_q      <= 8'h00;
      dir_q      <= 8'h00;
      miso_q     <= 1'b0;
    end else begin
      in_s1_q    <= in_s1_d;
      in_s2_q    <= in_s2_d;
      in_a_q     <= in_a_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      vld_q      <= vld_d;
      armed_q    <= armed_d;
      miso_oeb_q <= miso_oeb_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      out_q      <= out_d;
      dir_q      <= dir_d;
      miso_q     <= miso_d;
    end
  end

  assign out      = out_q;
  assign oeb      = {~dir_q, 8'hFF};
  assign miso     = miso_q;
  assign miso_oeb = miso_oeb_q;

endmodule

// File: tb/tb_pad_spi_regs.sv
// Scoreboard bench for pad_spi_regs: frames push expectations, a monitor pops them
// each time the DUT ends a frame (miso_oeb rising) and compares outputs and captured MISO.
module tb_pad_spi_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          sck = 1'b0;
  bit          mosi = 1'b0;
  bit          csb = 1'b1;
  bit   [4:0]  gp = 5'd0;
  logic [7:0]  in_pad;
  logic [7:0]  out;
  logic [15:0] oeb;
  logic        miso;
  logic        miso_oeb;

  assign in_pad = {gp, csb, mosi, sck};

  pad_spi_regs dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_pad),
    .out      (out),
    .oeb      (oeb),
    .miso     (miso),
    .miso_oeb (miso_oeb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  out;
    logic [15:0] oeb;
    bit          chk_rx;
    logic [7:0]  rx;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          chg_cyc = 0;
  int          rise16_cyc = 0;
  logic [23:0] prev_oo = 24'h0;
  logic [15:0] rx_sh = 16'h0;
  bit          mon_en = 1'b0;
  event        present_ev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ({out, oeb} !== prev_oo) begin
      prev_oo <= {out, oeb};
      chg_cyc <= cyc;
    end
  end

  // The bench acts as the SPI master and samples MISO on its own SCK rising edges.
  always @(posedge sck) begin
    if (!csb) rx_sh <= {rx_sh[14:0], miso};
  end

  always @(posedge miso_oeb) begin
    if (mon_en) ->present_ev;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(present_ev);
      repeat (2) @(negedge clk);
      if (sb.size() == 0) begin
        chk("unexpected_frame_end", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".out"}, {24'h0, out}, {24'h0, e.out});
        chk({e.name, ".oeb"}, {16'h0, oeb}, {16'h0, e.oeb});
        chk({e.name, ".miso"}, {31'h0, miso}, 32'd0);
        chk({e.name, ".miso_oeb"}, {31'h0, miso_oeb}, 32'd1);
        if (e.chk_rx) chk({e.name, ".rx"}, {24'h0, rx_sh[7:0]}, {24'h0, e.rx});
        if (e.chk_lat) chk({e.name, ".lat"}, chg_cyc - rise16_cyc, 32'd4);
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [7:0] o, input logic [15:0] oe,
                      input bit crx, input logic [7:0] rx, input bit cl);
    exp_t e;
    e.name = nm; e.out = o; e.oeb = oe; e.chk_rx = crx; e.rx = rx; e.chk_lat = cl;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic [15:0] w, input int i, input bit abort_same);
    mosi = (i < 16) ? w[15 - i] : 1'b0;
    clks(6);
    sck = 1'b1;
    if (i == 15) begin
      rise16_cyc = cyc;
      if (abort_same) csb = 1'b1;
    end
    clks(6);
    sck = 1'b0;
  endtask

  task automatic frame(input logic [15:0] w, input int nbits, input bit abort_same);
    clks(1);
    csb = 1'b0;
    clks(6);
    for (int i = 0; i < nbits; i++) send_bit(w, i, abort_same);
    clks(6);
    csb = 1'b1;
    clks(12);
  endtask

  initial begin : timeout
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clks(2);
    push("reset", 8'h00, 16'hFFFF, 1'b0, 8'h00, 1'b0);
    ->present_ev;
    clks(6);
    mon_en = 1'b1;

    push("wr_out", 8'h3C, 16'hFFFF, 1'b1, 8'h00, 1'b1);  frame(16'h803C, 16, 1'b0);
    push("wr_dir", 8'h3C, 16'h0FFF, 1'b1, 8'h00, 1'b1);  frame(16'h81F0, 16, 1'b0);
    push("rd_id",  8'h3C, 16'h0FFF, 1'b1, 8'hA5, 1'b0);  frame(16'h0300, 16, 1'b0);
    gp = 5'b10110;
    push("rd_in",  8'h3C, 16'h0FFF, 1'b1, 8'hB1, 1'b0);  frame(16'h0200, 16, 1'b0);
    gp = 5'b00000;
    push("abort12",   8'h3C, 16'h0FFF, 1'b0, 8'h00, 1'b0);  frame(16'h80FF, 12, 1'b0);
    push("abort_same", 8'h3C, 16'h0FFF, 1'b0, 8'h00, 1'b0); frame(16'h80FF, 16, 1'b1);
    push("overlong", 8'h55, 16'h0FFF, 1'b0, 8'h00, 1'b1);  frame(16'h8055, 24, 1'b0);
    push("rd_out",   8'h55, 16'h0FFF, 1'b1, 8'h55, 1'b0);  frame(16'h0000, 16, 1'b0);
    push("wr_bad",   8'h55, 16'h0FFF, 1'b1, 8'h00, 1'b0);  frame(16'h8577, 16, 1'b0);
    push("rd_dir",   8'h55, 16'h0FFF, 1'b1, 8'hF0, 1'b0);  frame(16'h0100, 16, 1'b0);

    // Reset in the middle of a write's data phase; the rest of that frame must be ignored.
    push("rst_mid", 8'h00, 16'hFFFF, 1'b0, 8'h00, 1'b0);
    clks(1);
    csb = 1'b0;
    clks(6);
    for (int i = 0; i < 12; i++) send_bit(16'h80AA, i, 1'b0);
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    push("rst_rest", 8'h00, 16'hFFFF, 1'b0, 8'h00, 1'b0);
    for (int i = 12; i < 16; i++) send_bit(16'h80AA, i, 1'b0);
    clks(6);
    csb = 1'b1;
    clks(12);

    push("wr_after_rst", 8'hC3, 16'hFFFF, 1'b1, 8'h00, 1'b1); frame(16'h80C3, 16, 1'b0);
    push("rd_after_rst", 8'hC3, 16'hFFFF, 1'b1, 8'hC3, 1'b0); frame(16'h0000, 16, 1'b0);

    clks(20);
    chk("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
